// File: rtl/data_memory_if.sv
// Data-memory port between the core (master) and the memory responder (slave).
// Signal names follow the core's DATA_MEM_* pin names.
interface data_memory_if;
    logic [3:0]  READ;
    logic [2:0]  WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;

    modport master (
        output READ,
        output WRITE,
        output ADDRESS,
        output WRITE_DATA,
        input  READ_DATA,
        input  BUSYWAIT
    );

    modport slave (
        input  READ,
        input  WRITE,
        input  ADDRESS,
        input  WRITE_DATA,
        output READ_DATA,
        output BUSYWAIT
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised data memory with a fixed BUSYWAIT latency; byte/half/word
// loads and stores with sign/zero extension on loads.
module data_memory #(
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    data_memory_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;

    logic [3:0]  read_p0;
    logic [2:0]  write_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic        request;
    logic        in_idle;
    logic        last_beat;
    logic        perform;

    logic [3:0]  op_read;
    logic [2:0]  op_write;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        op_store;
    logic        op_load;
    logic [AW-1:0] op_index;
    logic [1:0]  op_lane;
    logic [31:0] cur_word;
    logic        unused_addr_bits;

    logic [31:0] mem [MEM_DEPTH];

    // Extend the selected lane of a memory word according to load funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  lane);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  return {{24{byte_v[7]}}, byte_v};
            3'b001:  return {{16{half_v[15]}}, half_v};
            3'b100:  return {24'h0, byte_v};
            3'b101:  return {16'h0, half_v};
            default: return word;
        endcase
    endfunction

    // Merge right-aligned store data into the addressed lanes of a word.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] merged;
        merged = old;
        case (size)
            2'b00: merged[{lane, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (lane[1]) merged[31:16] = data[15:0];
                else         merged[15:0]  = data[15:0];
            end
            default: merged = data;
        endcase
        return merged;
    endfunction

    assign request   = bus.READ[3] | bus.WRITE[2];
    assign in_idle   = (state == IDLE);
    assign last_beat = (cnt == 4'(LATENCY - 1));

    // In IDLE the live bus is the operand (LATENCY=1 performs at the latch edge).
    assign op_read  = in_idle ? bus.READ       : read_p0;
    assign op_write = in_idle ? bus.WRITE      : write_p0;
    assign op_addr  = in_idle ? bus.ADDRESS    : addr_p0;
    assign op_wdata = in_idle ? bus.WRITE_DATA : wdata_p0;

    assign op_store = op_write[2];
    assign op_load  = op_read[3] & ~op_write[2];
    assign op_index = op_addr[AW+1:2];
    assign op_lane  = op_addr[1:0];
    assign cur_word = mem[op_index];
    assign unused_addr_bits = ^op_addr[31:AW+2];

    assign perform = ~RESET &
                     ((in_idle && request && (LATENCY == 1)) ||
                      (state == BUSY && last_beat));

    // State register and access counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE:    if (request) cnt <= 4'd1;
                BUSY:    cnt <= cnt + 4'd1;
                default: cnt <= 4'd0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (request) state_next = (LATENCY == 1) ? ACK : BUSY;
            end
            BUSY: begin
                if (last_beat) state_next = ACK;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.BUSYWAIT = 1'b0;
        case (state)
            IDLE:    bus.BUSYWAIT = request & ~RESET;
            BUSY:    bus.BUSYWAIT = ~RESET;
            default: bus.BUSYWAIT = 1'b0;
        endcase
    end

    // Request capture at the latch edge; later bus changes are ignored
    always_ff @(posedge CLK) begin
        if (in_idle && request) begin
            read_p0  <= bus.READ;
            write_p0 <= bus.WRITE;
            addr_p0  <= bus.ADDRESS;
            wdata_p0 <= bus.WRITE_DATA;
        end
    end

    // Completing edge: array update and load result
    always_ff @(posedge CLK) begin
        if (perform && op_store) begin
            mem[op_index] <= store_merge(cur_word, op_wdata, op_write[1:0], op_lane);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.READ_DATA <= 32'h0;
        end else if (perform && op_load) begin
            bus.READ_DATA <= load_extend(cur_word, op_read[2:0], op_lane);
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed scenarios plus randomized accesses against a
// byte-addressed reference model; a second instance covers LATENCY=1.
module tb_data_memory;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_if bus0 ();
    data_memory_if bus1 ();

    data_memory #(.MEM_DEPTH(256), .LATENCY(4)) dut0 (.CLK(clk), .RESET(rst), .bus(bus0));
    data_memory #(.MEM_DEPTH(256), .LATENCY(1)) dut1 (.CLK(clk), .RESET(rst), .bus(bus1));

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  mb [1024];
    logic [31:0] model_rd = 32'h0;

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [2:0] f3);
        int a, w, h;
        logic [7:0]  b;
        logic [15:0] hv;
        logic [31:0] wv;
        a  = int'(addr & 32'h3FF);
        w  = a & ~3;
        h  = a & ~1;
        wv = {mb[w+3], mb[w+2], mb[w+1], mb[w]};
        b  = mb[a];
        hv = {mb[h+1], mb[h]};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{hv[15]}}, hv};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, hv};
            default: return wv;
        endcase
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
        int a, w, h;
        a = int'(addr & 32'h3FF);
        w = a & ~3;
        h = a & ~1;
        case (size)
            2'b00: mb[a] = d[7:0];
            2'b01: begin mb[h] = d[7:0]; mb[h+1] = d[15:8]; end
            default: begin
                mb[w] = d[7:0]; mb[w+1] = d[15:8]; mb[w+2] = d[23:16]; mb[w+3] = d[31:24];
            end
        endcase
    endtask

    task automatic drive(input bit which, input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (which) begin
            bus1.READ = rd; bus1.WRITE = wr; bus1.ADDRESS = a; bus1.WRITE_DATA = wd;
        end else begin
            bus0.READ = rd; bus0.WRITE = wr; bus0.ADDRESS = a; bus0.WRITE_DATA = wd;
        end
    endtask

    function automatic logic busy_of(input bit which);
        return which ? bus1.BUSYWAIT : bus0.BUSYWAIT;
    endfunction

    function automatic logic [31:0] rdata_of(input bit which);
        return which ? bus1.READ_DATA : bus0.READ_DATA;
    endfunction

    // One access: request in the next IDLE cycle, count BUSYWAIT-high cycles,
    // return READ_DATA sampled in the ACK cycle. hold keeps the request up and
    // scrambles address/data until ACK.
    task automatic access(input bit which, input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rdata, output int hi);
        @(negedge clk);
        drive(which, rd, wr, a, wd);
        #1;
        hi = 0;
        while (busy_of(which) && hi < 40) begin
            hi++;
            @(negedge clk);
            if (hold) drive(which, rd, wr, $urandom, $urandom);
            else      drive(which, 4'h0, 3'h0, $urandom, $urandom);
            #1;
        end
        rdata = rdata_of(which);
        drive(which, 4'h0, 3'h0, 32'h0, 32'h0);
        if (hi >= 40) begin
            tests_run++; tests_failed++;
            $display("FAIL access_timeout: BUSYWAIT still high after %0d cycles, required to drop", hi);
        end
    endtask

    task automatic test_reset();
        int hi;
        @(negedge clk);
        rst = 1'b1;
        drive(0, 4'b1010, 3'b000, 32'h40, 32'h0);
        #1;
        tests_run++;
        if (bus0.BUSYWAIT !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busywait: got %b, required 0", bus0.BUSYWAIT);
        end
        tests_run++;
        if (bus0.READ_DATA !== 32'h0) begin
            tests_failed++; $display("FAIL reset_read_data: got %h, required 00000000", bus0.READ_DATA);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus0.BUSYWAIT !== 1'b1) begin
            tests_failed++; $display("FAIL reset_release_busy: got %b, required 1", bus0.BUSYWAIT);
        end
        hi = 0;
        while (bus0.BUSYWAIT && hi < 40) begin
            hi++;
            @(negedge clk);
            drive(0, 4'h0, 3'h0, 32'h0, 32'h0);
            #1;
        end
        tests_run++;
        if (hi != 4) begin
            tests_failed++; $display("FAIL reset_latency: busy %0d cycles, required 4", hi);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus0.BUSYWAIT !== 1'b0) begin
            tests_failed++; $display("FAIL reset_idle_after_ack: got %b, required 0", bus0.BUSYWAIT);
        end
    endtask

    task automatic test_roundtrip();
        logic [31:0] rd; int hi;
        access(0, 4'b0000, 3'b110, 32'h40, 32'hDEADBEEF, 0, rd, hi);
        m_store(32'h40, 2'b10, 32'hDEADBEEF);
        tests_run++;
        if (hi != 4) begin
            tests_failed++; $display("FAIL sw_latency: busy %0d cycles, required 4", hi);
        end
        access(0, 4'b1010, 3'b000, 32'h40, 32'h0, 0, rd, hi);
        model_rd = m_load(32'h40, 3'b010);
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL lw_roundtrip: got %h, required deadbeef", rd);
        end
        access(0, 4'b1010, 3'b000, 32'h440, 32'h0, 0, rd, hi);
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL lw_wrap_alias: got %h, required deadbeef", rd);
        end
    endtask

    task automatic test_merge();
        logic [31:0] rd; int hi;
        logic [3:0]  ld_rd [4]  = '{4'b1000, 4'b1100, 4'b1001, 4'b1101};
        logic [31:0] ld_a  [4]  = '{32'h42, 32'h42, 32'h42, 32'h43};
        logic [31:0] ld_e  [4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFDE80, 32'h0000DE80};
        access(0, 4'b0000, 3'b100, 32'h42, 32'hFFFFFF80, 0, rd, hi);
        m_store(32'h42, 2'b00, 32'hFFFFFF80);
        tests_run++;
        if (rd !== model_rd) begin
            tests_failed++; $display("FAIL sb_keeps_read_data: got %h, required %h", rd, model_rd);
        end
        access(0, 4'b0000, 3'b101, 32'h40, 32'hABCD1234, 0, rd, hi);
        m_store(32'h40, 2'b01, 32'hABCD1234);
        access(0, 4'b1010, 3'b000, 32'h40, 32'h0, 0, rd, hi);
        model_rd = m_load(32'h40, 3'b010);
        tests_run++;
        if (rd !== 32'hDE801234) begin
            tests_failed++; $display("FAIL merge_lw: got %h, required de801234", rd);
        end
        for (int i = 0; i < 4; i++) begin
            access(0, ld_rd[i], 3'b000, ld_a[i], 32'h0, 0, rd, hi);
            model_rd = m_load(ld_a[i], ld_rd[i][2:0]);
            tests_run++;
            if (rd !== ld_e[i]) begin
                tests_failed++;
                $display("FAIL merge_load_%0d: got %h, required %h", i, rd, ld_e[i]);
            end
        end
    endtask

    task automatic test_mid_change();
        logic [31:0] rd; int hi;
        access(0, 4'b0000, 3'b110, 32'h14, 32'h5555AAAA, 0, rd, hi);
        m_store(32'h14, 2'b10, 32'h5555AAAA);
        access(0, 4'b0000, 3'b110, 32'h10, 32'hCAFEF00D, 1, rd, hi);
        m_store(32'h10, 2'b10, 32'hCAFEF00D);
        tests_run++;
        if (hi != 4) begin
            tests_failed++; $display("FAIL mid_change_latency: busy %0d cycles, required 4", hi);
        end
        access(0, 4'b1010, 3'b000, 32'h10, 32'h0, 0, rd, hi);
        model_rd = m_load(32'h10, 3'b010);
        tests_run++;
        if (rd !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL mid_change_data: got %h, required cafef00d", rd);
        end
        access(0, 4'b1010, 3'b000, 32'h14, 32'h0, 0, rd, hi);
        model_rd = m_load(32'h14, 3'b010);
        tests_run++;
        if (rd !== 32'h5555AAAA) begin
            tests_failed++; $display("FAIL mid_change_neighbour: got %h, required 5555aaaa", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int hi;
        access(0, 4'b0000, 3'b110, 32'h20, 32'h0, 0, rd, hi);
        m_store(32'h20, 2'b10, 32'h0);
        @(negedge clk);
        drive(0, 4'b0000, 3'b110, 32'h20, 32'h11111111);
        @(negedge clk);
        drive(0, 4'h0, 3'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus0.BUSYWAIT !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid_busy: got %b, required 0", bus0.BUSYWAIT);
        end
        tests_run++;
        if (bus0.READ_DATA !== 32'h0) begin
            tests_failed++; $display("FAIL reset_mid_read_data: got %h, required 00000000", bus0.READ_DATA);
        end
        @(negedge clk);
        rst = 1'b0;
        model_rd = 32'h0;
        #1;
        tests_run++;
        if (bus0.BUSYWAIT !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid_idle: got %b, required 0", bus0.BUSYWAIT);
        end
        access(0, 4'b1010, 3'b000, 32'h20, 32'h0, 0, rd, hi);
        model_rd = m_load(32'h20, 3'b010);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++; $display("FAIL reset_mid_no_write: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_rw_both();
        logic [31:0] rd; int hi;
        access(0, 4'b1010, 3'b000, 32'h40, 32'h0, 0, rd, hi);
        model_rd = m_load(32'h40, 3'b010);
        access(0, 4'b1010, 3'b110, 32'h8, 32'hA5A5A5A5, 0, rd, hi);
        m_store(32'h8, 2'b10, 32'hA5A5A5A5);
        tests_run++;
        if (rd !== 32'hDE801234) begin
            tests_failed++; $display("FAIL rw_both_read_data: got %h, required de801234", rd);
        end
        access(0, 4'b1010, 3'b000, 32'h8, 32'h0, 0, rd, hi);
        model_rd = m_load(32'h8, 3'b010);
        tests_run++;
        if (rd !== 32'hA5A5A5A5) begin
            tests_failed++; $display("FAIL rw_both_stored: got %h, required a5a5a5a5", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  seen;
        logic [9:0]  expect_v;
        logic [31:0] rd_a, rd_b;
        rd_a = 32'h0; rd_b = 32'h0;
        for (int i = 0; i < 10; i++) expect_v[i] = ((i % 5) != 4);
        @(negedge clk);
        drive(0, 4'b1010, 3'b000, 32'h8, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            seen[i] = bus0.BUSYWAIT;
            if (i == 4) rd_a = bus0.READ_DATA;
            if (i == 9) begin
                rd_b = bus0.READ_DATA;
                drive(0, 4'h0, 3'h0, 32'h0, 32'h0);
            end else begin
                @(negedge clk);
            end
        end
        tests_run++;
        if (seen !== expect_v) begin
            tests_failed++; $display("FAIL b2b_busy_pattern: got %b, required %b", seen, expect_v);
        end
        tests_run++;
        if (rd_a !== 32'hA5A5A5A5 || rd_b !== 32'hA5A5A5A5) begin
            tests_failed++; $display("FAIL b2b_read_data: got %h/%h, required a5a5a5a5", rd_a, rd_b);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp_v;
        logic [3:0]  rdv;
        logic [2:0]  wrv;
        int hi, kind;
        for (int w = 0; w < 64; w++) begin
            d = $urandom;
            access(0, 4'b0000, 3'b110, 32'(w * 4), d, 0, rd, hi);
            m_store(32'(w * 4), 2'b10, d);
        end
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 2);
            a = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 255));
            d = $urandom;
            rdv = (kind != 1) ? {1'b1, 3'($urandom_range(0, 7))} : 4'h0;
            wrv = (kind != 0) ? {1'b1, 2'($urandom_range(0, 2))} : 3'h0;
            access(0, rdv, wrv, a, d, 0, rd, hi);
            tests_run++;
            if (hi != 4) begin
                tests_failed++; $display("FAIL rand_latency_%0d: busy %0d cycles, required 4", n, hi);
            end
            if (wrv[2]) begin
                m_store(a, wrv[1:0], d);
                exp_v = model_rd;
            end else begin
                exp_v = m_load(a, rdv[2:0]);
                model_rd = exp_v;
            end
            tests_run++;
            if (rd !== exp_v) begin
                tests_failed++;
                $display("FAIL rand_data_%0d: rd=%b wr=%b addr=%h got %h, required %h",
                         n, rdv, wrv, a, rd, exp_v);
            end
        end
    endtask

    task automatic test_latency1();
        logic [31:0] rd; int hi;
        access(1, 4'b0000, 3'b110, 32'h4, 32'h13579BDF, 0, rd, hi);
        tests_run++;
        if (hi != 1) begin
            tests_failed++; $display("FAIL lat1_store_latency: busy %0d cycles, required 1", hi);
        end
        access(1, 4'b1010, 3'b000, 32'h4, 32'h0, 0, rd, hi);
        tests_run++;
        if (hi != 1) begin
            tests_failed++; $display("FAIL lat1_load_latency: busy %0d cycles, required 1", hi);
        end
        tests_run++;
        if (rd !== 32'h13579BDF) begin
            tests_failed++; $display("FAIL lat1_lw: got %h, required 13579bdf", rd);
        end
        access(1, 4'b1000, 3'b000, 32'h4, 32'h0, 0, rd, hi);
        tests_run++;
        if (rd !== 32'hFFFFFFDF) begin
            tests_failed++; $display("FAIL lat1_lb: got %h, required ffffffdf", rd);
        end
        access(1, 4'b1101, 3'b000, 32'h6, 32'h0, 0, rd, hi);
        tests_run++;
        if (rd !== 32'h00001357) begin
            tests_failed++; $display("FAIL lat1_lhu: got %h, required 00001357", rd);
        end
    endtask

    initial begin
        drive(0, 4'h0, 3'h0, 32'h0, 32'h0);
        drive(1, 4'h0, 3'h0, 32'h0, 32'h0);
        test_reset();
        test_roundtrip();
        test_merge();
        test_mid_change();
        test_reset_mid();
        test_rw_both();
        test_back_to_back();
        test_random();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory that acts as the responder on the CPU data-memory port. It accepts byte, halfword and word loads and stores, and stalls the core with BUSYWAIT for a fixed, parameterised latency. It returns sign- or zero-extended load data in the cycle BUSYWAIT drops. It sits directly on the core's DATA_MEM_* pins, or behind a cache in later revisions.

## Interface
- MEM_DEPTH, 256: number of 32-bit words; power of two; word index = ADDRESS[log2(MEM_DEPTH)+1:2].
- LATENCY, 4: total BUSYWAIT-high cycles per access; legal range 1..15.
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- READ  input  4  [3] = load enable; [2:0] = funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- WRITE  input  3  [2] = store enable; [1:0] = funct3[1:0]: 00 SB, 01 SH, 10 SW.
- ADDRESS  input  32  byte address.
- WRITE_DATA  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- READ_DATA  output  32  extended load result; reset 0.
- BUSYWAIT  output  1  high while an access is pending; reset 0.

## Operation
- States: IDLE, BUSY, ACK. Reset enters IDLE and clears the counter and READ_DATA.
- Request = READ[3] | WRITE[2].
- IDLE, no request: BUSYWAIT=0.
- IDLE, with request:
  - BUSYWAIT=1 combinationally in the same cycle, so the core stalls with no bubble.
  - At the edge, READ, WRITE, ADDRESS and WRITE_DATA are latched, the counter is set to 1, and the FSM goes to BUSY. If LATENCY=1 it goes straight to ACK and the access is performed at that edge.
- BUSY: BUSYWAIT=1; the counter increments each edge. At the edge where counter==LATENCY-1 the latched access is performed and the FSM goes to ACK.
- ACK: BUSYWAIT=0 for exactly one cycle; READ_DATA is valid for a load. The next edge returns to IDLE unconditionally.
- Inputs are ignored from the latch edge until ACK; mid-access changes to the request have no effect.
- Byte lane = ADDRESS[1:0].
  - Byte ops use all of ADDRESS[1:0].
  - Halfword ops use ADDRESS[1]; ADDRESS[0] is ignored.
  - Word ops ignore ADDRESS[1:0]; misaligned accesses are never trapped.
- Stores write only the addressed lanes; the other lanes keep their values.
- Loads:
  - LB/LH sign-extend bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - Undefined funct3 values return the full word.
- READ_DATA holds its last value until the next load completes; it is unchanged by stores.
- Address bits above the word index are ignored, so addresses wrap modulo MEM_DEPTH*4.
- If READ[3] and WRITE[2] are both set, the access is treated as a store; READ_DATA is unchanged.
- RESET mid-access aborts it with no memory update: BUSYWAIT=0 and state IDLE immediately (async). Memory array contents are never cleared by RESET.
- A request still present in IDLE after ACK (core stalled elsewhere) is treated as a new access and re-executed. This is harmless for loads and idempotent for stores.

## Timing
- Request sampled first in cycle t (IDLE): BUSYWAIT high in cycles t..t+LATENCY-1, low in t+LATENCY (ACK).
- The core advances at the end of the ACK cycle; it captures READ_DATA at that edge.
- Back-to-back accesses: minimum spacing is LATENCY+1 cycles per access (ACK cycle plus LATENCY busy cycles).
- BUSYWAIT is a combinational function of the state and, in IDLE, of READ[3]|WRITE[2]. There is no path from ADDRESS or WRITE_DATA to BUSYWAIT.
- READ_DATA is registered; it changes only on the completing edge or on RESET.

## Test plan
- Reset:
  - Stimulus: assert RESET with READ=4'b1010 held.
  - Expected during reset: READ_DATA=0, BUSYWAIT=0.
  - Expected after release: BUSYWAIT rises in the same cycle, stays high exactly 4 cycles (LATENCY=4), then is low one cycle.
- SW/LW round trip:
  - Stimulus: SW 0xDEADBEEF to 0x40, then LW 0x40.
  - Expected: READ_DATA=0xDEADBEEF in the ACK cycle; wrap alias 0x440 (MEM_DEPTH=256) also reads 0xDEADBEEF.
- Byte/halfword merge:
  - Stimulus: after the SW above, SB 0x80 to 0x42, then SH 0x1234 to 0x40.
  - Expected LW 0x40: 0xDE801234.
  - Expected LB 0x42: 0xFFFFFF80; LBU 0x42: 0x00000080.
  - Expected LH 0x42: 0xFFFFDE80; LHU 0x43: 0x0000DE80.
- Input change mid-access:
  - Stimulus: change ADDRESS/WRITE_DATA during BUSY of an SW to 0x10.
  - Expected: only the originally latched data is written to 0x10.
- Reset mid-access:
  - Stimulus: start SW 0x11111111 to 0x20 over 0x0; pulse RESET in the 2nd BUSY cycle; then LW 0x20.
  - Expected: BUSYWAIT drops immediately; LW returns 0x00000000 (no write performed).
- Simultaneous read+write:
  - Stimulus: READ=4'b1010, WRITE=3'b110, WRITE_DATA=0xA5A5A5A5 to 0x8.
  - Expected: READ_DATA unchanged; a following LW 0x8 returns 0xA5A5A5A5.
- LATENCY=1 build:
  - Stimulus: any load.
  - Expected: BUSYWAIT high exactly 1 cycle, then ACK.
